// File: rtl/param_toggle_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : param_toggle_counter_pkg
// Description : Shared count-mode encoding and default parameter constants
//               for the parameterised toggle counter and its checker.
// Revision    : 1.0 - initial release
// ============================================================================
package param_toggle_counter_pkg;

  // Count mode encoding; RSVD is treated as HOLD and flagged as an error.
  typedef enum logic [1:0] {
    MODE_UP   = 2'd0,
    MODE_DOWN = 2'd1,
    MODE_HOLD = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  localparam int c_def_width     = 4;
  localparam int c_def_max_count = 15;
  localparam bit c_def_toggle_en = 1'b1;

endpackage : param_toggle_counter_pkg
`default_nettype wire

// File: rtl/param_toggle_counter_checker.sv
`default_nettype none
// ============================================================================
// Module      : count_checker
// Description : Protocol checker for the toggle counter. Flags an
//               out-of-range load and a reserved count mode, and keeps a
//               sticky error register. Usable as a stand-alone monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module count_checker
  import param_toggle_counter_pkg::*;
#(
  parameter int WIDTH     = c_def_width,
  parameter int MAX_COUNT = c_def_max_count
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  mode_e            mode,
  input  logic             clr_err,
  output logic             ovf_load,
  output logic             err
);

  localparam logic [WIDTH:0] c_max = (WIDTH+1)'(MAX_COUNT);

  logic w_rsvd_mode;
  logic w_new_err;
  logic r_err;

  // Error sources; mode is ignored while a load takes priority.
  always_comb begin
    ovf_load    = load && ({1'b0, load_val} > c_max);
    w_rsvd_mode = !load && en && (mode == MODE_RSVD);
    w_new_err   = ovf_load || w_rsvd_mode;
  end

  // Sticky error: a fresh error on this edge beats a clear request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_new_err) begin
      r_err <= 1'b1;
    end else if (clr_err) begin
      r_err <= 1'b0;
    end
  end

  assign err = r_err;

endmodule : count_checker
`default_nettype wire

// File: rtl/param_toggle_counter.sv
`default_nettype none
// ============================================================================
// Module      : param_toggle_counter
// Description : Up/down modulo-(MAX_COUNT+1) counter with synchronous load,
//               single-cycle wrap pulse, optional toggle-on-wrap flag and a
//               sticky protocol-error flag from the count_checker instance.
// Revision    : 1.0 - initial release
// ============================================================================
module param_toggle_counter
  import param_toggle_counter_pkg::*;
#(
  parameter int WIDTH     = c_def_width,
  parameter int MAX_COUNT = c_def_max_count,
  parameter bit TOGGLE_EN = c_def_toggle_en
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  mode_e            mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_err,
  output logic [WIDTH-1:0] count,
  output logic             t,
  output logic             wrap,
  output logic             err
);

  // One extra bit so the increment past MAX_COUNT (even 2**WIDTH-1) and the
  // borrow below zero are both visible without wrapping silently.
  localparam logic [WIDTH:0] c_max = (WIDTH+1)'(MAX_COUNT);

  logic [WIDTH-1:0] r_count;
  logic             r_t;
  logic             r_wrap;
  logic [WIDTH-1:0] w_count_nxt;
  logic             w_t_nxt;
  logic             w_wrap_nxt;
  logic [WIDTH:0]   w_inc;
  logic [WIDTH:0]   w_dec;
  logic             w_ovf_load;

  count_checker #(
    .WIDTH     (WIDTH),
    .MAX_COUNT (MAX_COUNT)
  ) u_checker (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .en       (en),
    .mode     (mode),
    .clr_err  (clr_err),
    .ovf_load (w_ovf_load),
    .err      (err)
  );

  // Next-state datapath: load beats enabled counting, which beats hold.
  always_comb begin
    w_inc       = {1'b0, r_count} + 1'b1;
    w_dec       = {1'b0, r_count} - 1'b1;
    w_count_nxt = r_count;
    w_wrap_nxt  = 1'b0;
    w_t_nxt     = r_t;
    if (load) begin
      w_count_nxt = w_ovf_load ? c_max[WIDTH-1:0] : load_val;
    end else if (en && (mode == MODE_UP)) begin
      if (w_inc > c_max) begin
        w_count_nxt = '0;
        w_wrap_nxt  = 1'b1;
      end else begin
        w_count_nxt = w_inc[WIDTH-1:0];
      end
    end else if (en && (mode == MODE_DOWN)) begin
      if (w_dec[WIDTH]) begin
        w_count_nxt = c_max[WIDTH-1:0];
        w_wrap_nxt  = 1'b1;
      end else begin
        w_count_nxt = w_dec[WIDTH-1:0];
      end
    end
    if (w_wrap_nxt && TOGGLE_EN) begin
      w_t_nxt = ~r_t;
    end
  end

  // Output registers; reset clears them immediately without a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_t     <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_t     <= w_t_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  assign count = r_count;
  assign t     = r_t;
  assign wrap  = r_wrap;

endmodule : param_toggle_counter
`default_nettype wire

// File: tb/tb_param_toggle_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_param_toggle_counter
// Description : Self-checking bench for param_toggle_counter (WIDTH=4,
//               MAX_COUNT=9). A behavioural model is compared every cycle and
//               directed sequences pin literal expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_param_toggle_counter;
  import param_toggle_counter_pkg::*;

  localparam int W   = 4;
  localparam int MAX = 9;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  mode_e        mode;
  logic         load;
  logic [W-1:0] load_val;
  logic         clr_err;
  logic [W-1:0] count;
  logic         t;
  logic         wrap;
  logic         err;

  int total  = 0;
  int passed = 0;

  // Behavioural model state
  int m_count;
  int m_t;
  int m_wrap;
  int m_err;

  param_toggle_counter #(
    .WIDTH     (W),
    .MAX_COUNT (MAX),
    .TOGGLE_EN (1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .load     (load),
    .load_val (load_val),
    .clr_err  (clr_err),
    .count    (count),
    .t        (t),
    .wrap     (wrap),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Model: modulo arithmetic on integers, straight from the counting rules.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_count = 0; m_t = 0; m_wrap = 0; m_err = 0;
    end else begin
      int  nc;
      bit  wr;
      bit  ne;
      nc = m_count;
      wr = 0;
      ne = (load && (int'(load_val) > MAX)) || (!load && en && mode == MODE_RSVD);
      if (load) nc = (int'(load_val) > MAX) ? MAX : int'(load_val);
      else if (en && mode == MODE_UP) begin
        nc = (m_count + 1) % (MAX + 1);
        wr = (m_count == MAX);
      end else if (en && mode == MODE_DOWN) begin
        nc = (m_count + MAX) % (MAX + 1);
        wr = (m_count == 0);
      end
      m_count = nc;
      m_wrap  = wr;
      if (wr) m_t = 1 - m_t;
      if (ne) m_err = 1;
      else if (clr_err) m_err = 0;
    end
  end

  // Compare process on the inactive edge
  always @(negedge clk) begin
    chk("model_count", int'(count), m_count);
    chk("model_t",     int'(t),     m_t);
    chk("model_wrap",  int'(wrap),  m_wrap);
    chk("model_err",   int'(err),   m_err);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int up_exp[12];
    int dn_exp[5];
    up_exp = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    dn_exp = '{2, 1, 0, 9, 8};

    rst = 1'b1; en = 1'b0; mode = MODE_HOLD; load = 1'b0;
    load_val = '0; clr_err = 1'b0;
    #1;
    chk("reset_count", int'(count), 0);
    chk("reset_t",     int'(t),     0);
    chk("reset_wrap",  int'(wrap),  0);
    chk("reset_err",   int'(err),   0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Count up 12 edges
    en = 1'b1; mode = MODE_UP;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("up_count", int'(count), up_exp[i]);
      chk("up_wrap",  int'(wrap),  (i == 9) ? 1 : 0);
      chk("up_t",     int'(t),     (i >= 9) ? 1 : 0);
    end

    // Load 3 then count down 5 edges
    load = 1'b1; load_val = 4'd3;
    tick();
    chk("load3_count", int'(count), 3);
    chk("load3_wrap",  int'(wrap),  0);
    chk("load3_t",     int'(t),     1);
    load = 1'b0; mode = MODE_DOWN;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("dn_count", int'(count), dn_exp[i]);
      chk("dn_wrap",  int'(wrap),  (i == 3) ? 1 : 0);
    end
    chk("dn_t", int'(t), 0);

    // Overflow load, clear, reserved mode, clear blocked by new error
    en = 1'b0; load = 1'b1; load_val = 4'd12;
    tick();
    chk("ovf_count", int'(count), 9);
    chk("ovf_err",   int'(err),   1);
    load = 1'b0; clr_err = 1'b1;
    tick();
    chk("clr_err", int'(err), 0);
    clr_err = 1'b0; en = 1'b1; mode = MODE_RSVD;
    tick();
    chk("rsvd_err",   int'(err),   1);
    chk("rsvd_count", int'(count), 9);
    clr_err = 1'b1;
    tick();
    chk("clr_vs_rsvd_err", int'(err), 1);
    clr_err = 1'b0;

    // Hold at 9 for 4 edges, then wrap up
    en = 1'b0; mode = MODE_UP;
    tick(); tick();
    en = 1'b1; mode = MODE_HOLD;
    tick(); tick();
    chk("hold_count", int'(count), 9);
    chk("hold_wrap",  int'(wrap),  0);
    mode = MODE_UP;
    tick();
    chk("hold_up_count", int'(count), 0);
    chk("hold_up_wrap",  int'(wrap),  1);
    chk("hold_up_t",     int'(t),     1);

    // Load wins over enabled count
    load = 1'b1; load_val = 4'd5;
    tick();
    chk("ldpri_count", int'(count), 5);
    chk("ldpri_wrap",  int'(wrap),  0);
    chk("ldpri_t",     int'(t),     1);

    // Reversal at zero: UP to DOWN wraps
    load_val = 4'd0;
    tick();
    load = 1'b0; mode = MODE_DOWN;
    tick();
    chk("rev_count", int'(count), 9);
    chk("rev_wrap",  int'(wrap),  1);
    chk("rev_t",     int'(t),     0);

    // Reach count 7 with t=1, then asynchronous reset between edges
    mode = MODE_UP;
    tick();
    load = 1'b1; load_val = 4'd6;
    tick();
    load = 1'b0;
    tick();
    chk("pre_rst_count", int'(count), 7);
    chk("pre_rst_t",     int'(t),     1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_count", int'(count), 0);
    chk("async_rst_t",     int'(t),     0);
    chk("async_rst_err",   int'(err),   0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick();
    chk("post_rst_count", int'(count), 1);
    chk("post_rst_wrap",  int'(wrap),  0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule : tb_param_toggle_counter
`default_nettype wire

// File: doc/param_toggle_counter.md
PARAM_TOGGLE_COUNTER -- requirements
Module: param_toggle_counter

Interface
REQ-001 Parameter WIDTH, default 4: count register width in bits; SHALL be >= 2.
REQ-002 Parameter MAX_COUNT, default 15: terminal count; SHALL satisfy 1 <= MAX_COUNT <= 2**WIDTH-1.
REQ-003 Parameter TOGGLE_EN, default 1: 1 = t toggles on every wrap; 0 = t held 0.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 en  input  1  count enable.
REQ-007 mode  input  2  count mode: UP, DOWN, HOLD, RSVD (package enum).
REQ-008 load  input  1  synchronous load strobe.
REQ-009 load_val  input  WIDTH  value to load.
REQ-010 clr_err  input  1  clears the sticky error flag.
REQ-011 count  output  WIDTH  current count, registered.
REQ-012 t  output  1  toggle flag, registered.
REQ-013 wrap  output  1  single-cycle pulse marking a terminal-count wrap, registered.
REQ-014 err  output  1  sticky protocol-error flag, registered.

Function
REQ-015 Per-edge priority SHALL be: load > (en and mode) > hold.
REQ-016 Load with load_val <= MAX_COUNT SHALL set count = load_val on the next edge; wrap = 0; t unchanged.
REQ-017 Load with load_val > MAX_COUNT SHALL set count = MAX_COUNT and set err.
REQ-018 With en=1 and mode=UP, count SHALL increment by 1; at MAX_COUNT it SHALL wrap to 0.
REQ-019 With en=1 and mode=DOWN, count SHALL decrement by 1; at 0 it SHALL wrap to MAX_COUNT.
REQ-020 mode=HOLD or en=0 SHALL leave count, t and err unchanged and drive wrap = 0.
REQ-021 mode=RSVD with en=1 SHALL behave as HOLD and set err.
REQ-022 On a wrap, wrap SHALL be 1 in the same cycle count shows its post-wrap value; it SHALL be 0 in every other cycle.
REQ-023 On a wrap, t SHALL invert when TOGGLE_EN=1.
REQ-024 Latency SHALL be one edge from input to count/t/wrap/err; there is no combinational input-to-output path.
REQ-025 Internal arithmetic SHALL use WIDTH+1 bits; count SHALL never exceed MAX_COUNT, including when MAX_COUNT < 2**WIDTH-1.
REQ-026 clr_err=1 SHALL clear err on the next edge unless a new error occurs on that same edge; a new error wins.
REQ-027 A mode change between cycles SHALL take effect on the next edge with no extra wrap or toggle; a reversal at the boundary (count=0, mode UP→DOWN) SHALL wrap.

Reset
REQ-028 Asserting rst SHALL immediately, without a clock, force count=0, t=0, wrap=0, err=0.
REQ-029 Reset mid-count SHALL abandon the operation; the first edge after deassertion SHALL process inputs normally from count=0.
REQ-030 Reset deassertion SHALL be synchronous to clk at the integration level; the block adds no synchroniser.

Structure
REQ-031 A shared package SHALL hold the mode enum (UP=0, DOWN=1, HOLD=2, RSVD=3) and the default parameter constants.
REQ-032 Error detection SHALL be a sub-module, count_checker: combinational flags (overflow load, reserved mode) plus the sticky err register, also bindable to the bench as a monitor.
REQ-033 The top SHALL contain only the count/t/wrap datapath and the checker instance.

Verification (WIDTH=4, MAX_COUNT=9, TOGGLE_EN=1)
REQ-034 Reset release, en=1, UP for 12 edges -> count 1..9,0,1,2; wrap=1 only with count=0; t 0→1.
REQ-035 Load load_val=3, then DOWN for 5 edges -> count 3,2,1,0,9,8; wrap=1 with count=9; t toggles once.
REQ-036 Load load_val=12 -> count=9, err=1; clr_err=1 on the next edge -> err=0; clr_err with simultaneous RSVD+en -> err stays 1.
REQ-037 load=1 and en=1 (UP) on the same edge, load_val=5 -> count=5, wrap=0, t unchanged.
REQ-038 rst asserted between edges at count=7, t=1 -> outputs zero before the next edge; after release UP -> count=1.
REQ-039 en=0 or HOLD for 4 edges at count=9 -> count stays 9, wrap=0; then UP -> count=0, wrap=1.
